ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline stage that feeds the 32-bit ALU. It captures decoded operands from the decode stage and resolves RAW hazards against the MEM and WB stages. It also translates the 2-bit main-decoder ALU class plus funct into the ALU's 3-bit op code. The result is a registered operand pair and op on a valid/ready handshake. The stage holds one entry, snoops writebacks while stalled, and supports a synchronous flush for branch/jump redirect.

## Interface
- P_NBITS, 32, datapath width
- P_STALL_W, 16, width of saturating stall counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard held entry and block capture this cycle
- in_valid  in  1  decode stage presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs_addr, in_rt_addr, in_rd_addr  in  5 each  register specifiers
- in_rs_data, in_rt_data  in  P_NBITS each  register-file read data
- in_imm  in  P_NBITS  sign-extended immediate
- in_aluop  in  2  main-decoder ALU class
- in_funct  in  6  R-type funct
- in_alusrc  in  1  1 = B operand is immediate
- in_regdst  in  1  1 = destination is rd, 0 = rt
- mem_wen, mem_waddr(5), mem_wdata(P_NBITS)  in  producer in MEM
- wb_wen, wb_waddr(5), wb_wdata(P_NBITS)  in  producer in WB
- out_valid  out  1  entry held for ALU
- out_ready  in  1  ALU stage consumes
- out_a, out_b  out  P_NBITS each  ALU operands
- out_op  out  3  ALU op
- out_store_data  out  P_NBITS  forwarded rt value for sw
- out_waddr  out  5  destination register
- out_illegal  out  1  unrecognised funct under aluop 10
- stall_cnt  out  P_STALL_W  cycles with out_valid && !out_ready, saturating

## Operation
- Ports: one clock `clk`, synchronous active-high `reset`.
- Single entry. in_ready = !flush && (!out_valid || out_ready).
- Capture when in_valid && in_ready. The entry stores rs_val, rt_val, imm, alusrc, op, waddr, illegal. Set out_valid = 1.
- Consume when out_valid && out_ready with no capture. Clear out_valid = 0.
- Capture-time forwarding, per source independently:
  - Priority: MEM match, then WB match, then register-file data.
  - A match is wen && waddr == addr && addr != 0.
- Hold-time snoop: while an entry is held and not replaced, a WB match on the stored rs/rt addr overwrites the stored value. MEM is not snooped.
- out_a = rs_val.
- out_b = alusrc ? imm : rt_val. This 2:1 mux is the only logic after the registers.
- out_store_data = rt_val.
- out_waddr = regdst ? rd : rt.
- Op decode:
  - aluop 00 → 010 (add)
  - aluop 01 → 110 (sub)
  - aluop 11 → 001 (or)
  - aluop 10 by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111
  - Any other funct under 10 → op 011, out_illegal = 1.
- Flush: next cycle out_valid = 0 and in_ready = 0 during the flush cycle. No capture happens even if in_valid. Flush overrides out_ready.
- stall_cnt increments each cycle out_valid && !out_ready. It saturates at all-ones and clears only on reset.

## Timing
- Reset values: out_valid = 0, all data outputs = 0, out_op = 000, out_illegal = 0, stall_cnt = 0. in_ready = 0 while reset is asserted.
- Latency: capture at edge N makes data visible on out_* after edge N. This is one cycle in → out.
- Throughput is one per cycle when out_ready is held high. Simultaneous consume and capture replaces the entry with no bubble.
- Outputs are stable while out_valid && !out_ready, except fields updated by the WB snoop.
- Reset mid-stall drops the entry and zeroes the counter in the same edge.
- Flush together with in_valid means the incoming instruction is not accepted. Upstream must re-present or drop it.

## Configuration
- FORWARD_EN defined: MEM/WB forwarding at capture and the WB snoop are active, as above.
- FORWARD_EN undefined: rs_val and rt_val come only from in_rs_data and in_rt_data. The mem_* and wb_* inputs are ignored, and hazards become the hazard unit's responsibility (stall). All other behaviour is identical.

## Test plan
- Reset is held 2 cycles then released → all outputs 0. in_ready = 1 on the first cycle after release.
- aluop 10, funct 101010, rs = 5, rt = 9, alusrc = 0, out_ready = 1 → next cycle out_a = 5, out_b = 9, out_op = 111, out_illegal = 0.
- FORWARD_EN: in_rs_addr = 3 with both mem (wdata = 0xAAAA) and wb (0xBBBB) writing r3, and regfile = 0x1111 → out_a = 0xAAAA. With waddr = 0 on both producers → out_a = regfile value.
- Capture with rt = r4, alusrc = 0, out_ready = 0 for 3 cycles; wb writes r4 = 0x55 on stall cycle 2 → out_b = 0x55 from the next cycle. stall_cnt = 3 at release.
- Held entry plus flush together with in_valid → out_valid = 0 next cycle. The new instruction is not captured (out_valid stays 0).
- aluop 10, funct 000000 → out_op = 011, out_illegal = 1. aluop 11 → out_op = 001.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: captures decoded operands, resolves RAW hazards, and translates the ALU op.
// Optional macro FORWARD_EN enables MEM/WB forwarding at capture and the WB snoop while held.
module ex_operand_stage #(
  parameter int unsigned P_NBITS   = 32,
  parameter int unsigned P_STALL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  // decode side
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs_addr,
  input  logic [4:0]           in_rt_addr,
  input  logic [4:0]           in_rd_addr,
  input  logic [P_NBITS-1:0]   in_rs_data,
  input  logic [P_NBITS-1:0]   in_rt_data,
  input  logic [P_NBITS-1:0]   in_imm,
  input  logic [1:0]           in_aluop,
  input  logic [5:0]           in_funct,
  input  logic                 in_alusrc,
  input  logic                 in_regdst,
  // producers in later stages
  input  logic                 mem_wen,
  input  logic [4:0]           mem_waddr,
  input  logic [P_NBITS-1:0]   mem_wdata,
  input  logic                 wb_wen,
  input  logic [4:0]           wb_waddr,
  input  logic [P_NBITS-1:0]   wb_wdata,
  // ALU side
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_NBITS-1:0]   out_a,
  output logic [P_NBITS-1:0]   out_b,
  output logic [2:0]           out_op,
  output logic [P_NBITS-1:0]   out_store_data,
  output logic [4:0]           out_waddr,
  output logic                 out_illegal,
  output logic [P_STALL_W-1:0] stall_cnt
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpBad = 3'b011;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  // Held entry
  logic                 valid_q,   valid_d;
  logic [P_NBITS-1:0]   rs_val_q,  rs_val_d;
  logic [P_NBITS-1:0]   rt_val_q,  rt_val_d;
  logic [P_NBITS-1:0]   imm_q,     imm_d;
  logic                 alusrc_q,  alusrc_d;
  logic [2:0]           op_q,      op_d;
  logic [4:0]           waddr_q,   waddr_d;
  logic                 illegal_q, illegal_d;
  logic [4:0]           rs_addr_q, rs_addr_d;
  logic [4:0]           rt_addr_q, rt_addr_d;
  logic [P_STALL_W-1:0] stall_q,   stall_d;

  logic                 capture;
  logic                 consume;
  logic [2:0]           dec_op;
  logic                 dec_illegal;
  logic [P_NBITS-1:0]   rs_fwd;
  logic [P_NBITS-1:0]   rt_fwd;
  logic                 snoop_rs;
  logic                 snoop_rt;

  assign in_ready = !reset && !flush && (!valid_q || out_ready);
  assign capture  = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  // ALU op translation
  always_comb begin
    dec_op      = OpAdd;
    dec_illegal = 1'b0;
    unique case (in_aluop)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b11: dec_op = OpOr;
      2'b10: begin
        case (in_funct)
          6'b100000: dec_op = OpAdd;
          6'b100010: dec_op = OpSub;
          6'b100100: dec_op = OpAnd;
          6'b100101: dec_op = OpOr;
          6'b101010: dec_op = OpSlt;
          default: begin
            dec_op      = OpBad;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: dec_op = OpAdd;
    endcase
  end

`ifdef FORWARD_EN
  logic mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;

  assign mem_hit_rs = mem_wen && (mem_waddr == in_rs_addr) && (in_rs_addr != 5'd0);
  assign mem_hit_rt = mem_wen && (mem_waddr == in_rt_addr) && (in_rt_addr != 5'd0);
  assign wb_hit_rs  = wb_wen && (wb_waddr == in_rs_addr) && (in_rs_addr != 5'd0);
  assign wb_hit_rt  = wb_wen && (wb_waddr == in_rt_addr) && (in_rt_addr != 5'd0);

  // MEM is younger than WB, so it wins when both write the same register.
  assign rs_fwd = mem_hit_rs ? mem_wdata : (wb_hit_rs ? wb_wdata : in_rs_data);
  assign rt_fwd = mem_hit_rt ? mem_wdata : (wb_hit_rt ? wb_wdata : in_rt_data);

  // Only WB is snooped: a MEM producer will still pass through WB later.
  assign snoop_rs = valid_q && wb_wen && (wb_waddr == rs_addr_q) && (rs_addr_q != 5'd0);
  assign snoop_rt = valid_q && wb_wen && (wb_waddr == rt_addr_q) && (rt_addr_q != 5'd0);
`else
  logic unused_fwd;

  assign rs_fwd     = in_rs_data;
  assign rt_fwd     = in_rt_data;
  assign snoop_rs   = 1'b0;
  assign snoop_rt   = 1'b0;
  assign unused_fwd = ^{mem_wen, mem_waddr, mem_wdata, wb_wen, wb_waddr, wb_wdata,
                        rs_addr_q, rt_addr_q};
`endif

  always_comb begin
    valid_d   = valid_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    imm_d     = imm_q;
    alusrc_d  = alusrc_q;
    op_d      = op_q;
    waddr_d   = waddr_q;
    illegal_d = illegal_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    stall_d   = stall_q;

    if (valid_q && !out_ready && (stall_q != {P_STALL_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      rs_val_d  = rs_fwd;
      rt_val_d  = rt_fwd;
      imm_d     = in_imm;
      alusrc_d  = in_alusrc;
      op_d      = dec_op;
      waddr_d   = in_regdst ? in_rd_addr : in_rt_addr;
      illegal_d = dec_illegal;
      rs_addr_d = in_rs_addr;
      rt_addr_d = in_rt_addr;
    end else begin
      if (snoop_rs) rs_val_d = wb_wdata;
      if (snoop_rt) rt_val_d = wb_wdata;
      if (consume)  valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      imm_q     <= '0;
      alusrc_q  <= 1'b0;
      op_q      <= 3'b000;
      waddr_q   <= 5'd0;
      illegal_q <= 1'b0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      imm_q     <= imm_d;
      alusrc_q  <= alusrc_d;
      op_q      <= op_d;
      waddr_q   <= waddr_d;
      illegal_q <= illegal_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_a          = rs_val_q;
  assign out_b          = alusrc_q ? imm_q : rt_val_q;
  assign out_op         = op_q;
  assign out_store_data = rt_val_q;
  assign out_waddr      = waddr_q;
  assign out_illegal    = illegal_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized self-checking bench for ex_operand_stage against a transaction-level model.
// Model follows FORWARD_EN the same way the design build does.
module tb_ex_operand_stage;

  localparam int unsigned StallW = 4;
  localparam int unsigned StallMax = (1 << StallW) - 1;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready;
  logic [4:0] in_rs_addr, in_rt_addr, in_rd_addr;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic [1:0] in_aluop;
  logic [5:0] in_funct;
  logic in_alusrc, in_regdst;
  logic mem_wen, wb_wen;
  logic [4:0] mem_waddr, wb_waddr;
  logic [31:0] mem_wdata, wb_wdata;
  logic out_valid, out_ready, out_illegal;
  logic [31:0] out_a, out_b, out_store_data;
  logic [2:0] out_op;
  logic [4:0] out_waddr;
  logic [StallW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the single held instruction
  bit          m_valid;
  logic [31:0] m_a, m_rt, m_imm;
  bit          m_alusrc, m_ill;
  logic [2:0]  m_op;
  logic [4:0]  m_waddr, m_rs_addr, m_rt_addr;
  int          m_stall;

  ex_operand_stage #(.P_NBITS(32), .P_STALL_W(StallW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_alusrc(in_alusrc), .in_regdst(in_regdst),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_store_data(out_store_data),
    .out_waddr(out_waddr), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit fwd_en();
`ifdef FORWARD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Value an operand should carry: newest in-flight producer first, r0 never forwarded.
  function automatic logic [31:0] operand(input logic [4:0] addr, input logic [31:0] rf);
    if (fwd_en() && addr != 0 && mem_wen && mem_waddr == addr) return mem_wdata;
    if (fwd_en() && addr != 0 && wb_wen && wb_waddr == addr) return wb_wdata;
    return rf;
  endfunction

  task automatic decode(output logic [2:0] op, output bit ill);
    ill = 1'b0;
    case (in_aluop)
      2'd0: op = 3'b010;
      2'd1: op = 3'b110;
      2'd3: op = 3'b001;
      default: begin
        if (in_funct == 6'd32)      op = 3'b010;
        else if (in_funct == 6'd34) op = 3'b110;
        else if (in_funct == 6'd36) op = 3'b000;
        else if (in_funct == 6'd37) op = 3'b001;
        else if (in_funct == 6'd42) op = 3'b111;
        else begin op = 3'b011; ill = 1'b1; end
      end
    endcase
  endtask

  function automatic bit model_ready();
    return !reset && !flush && (!m_valid || out_ready);
  endfunction

  task automatic model_step();
    bit accept;
    accept = in_valid && model_ready();
    if (reset) begin
      m_valid = 0; m_a = 0; m_rt = 0; m_imm = 0; m_alusrc = 0; m_op = 0;
      m_ill = 0; m_waddr = 0; m_rs_addr = 0; m_rt_addr = 0; m_stall = 0;
      return;
    end
    if (m_valid && !out_ready) m_stall = (m_stall < StallMax) ? m_stall + 1 : StallMax;
    if (flush) begin
      m_valid = 0;
    end else if (accept) begin
      m_valid   = 1;
      m_a       = operand(in_rs_addr, in_rs_data);
      m_rt      = operand(in_rt_addr, in_rt_data);
      m_imm     = in_imm;
      m_alusrc  = in_alusrc;
      m_waddr   = in_regdst ? in_rd_addr : in_rt_addr;
      m_rs_addr = in_rs_addr;
      m_rt_addr = in_rt_addr;
      decode(m_op, m_ill);
    end else begin
      if (m_valid && fwd_en() && wb_wen && wb_waddr != 0) begin
        if (wb_waddr == m_rs_addr) m_a = wb_wdata;
        if (wb_waddr == m_rt_addr) m_rt = wb_wdata;
      end
      if (out_ready) m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_valid);
    check_eq("stall_cnt", stall_cnt, m_stall);
    if (m_valid) begin
      check_eq("out_a", out_a, m_a);
      check_eq("out_b", out_b, m_alusrc ? m_imm : m_rt);
      check_eq("out_store_data", out_store_data, m_rt);
      check_eq("out_op", out_op, m_op);
      check_eq("out_waddr", out_waddr, m_waddr);
      check_eq("out_illegal", out_illegal, m_ill);
    end
  endtask

  // Inputs are set just after a falling edge; this samples in_ready, advances one cycle.
  task automatic step();
    #1;
    check_eq("in_ready", in_ready, model_ready());
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
    in_rs_data = 0; in_rt_data = 0; in_imm = 0;
    in_aluop = 0; in_funct = 0; in_alusrc = 0; in_regdst = 0;
    mem_wen = 0; mem_waddr = 0; mem_wdata = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                       input logic [31:0] rtd, input logic [1:0] aluop, input logic [5:0] funct);
    in_valid = 1; in_rs_addr = rs; in_rs_data = rsd; in_rt_addr = rt; in_rt_data = rtd;
    in_aluop = aluop; in_funct = funct; in_alusrc = 0; in_regdst = 1; in_rd_addr = 5'd7;
    in_imm = 32'h0000_0123;
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    step();
    step();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_a", out_a, 0);
    check_eq("rst_b", out_b, 0);
    check_eq("rst_op", out_op, 0);
    check_eq("rst_illegal", out_illegal, 0);
    check_eq("rst_stall", stall_cnt, 0);
    reset = 0;
    #1 check_eq("rst_release_ready", in_ready, 1);
    step();

    // slt
    instr(5'd1, 32'd5, 5'd2, 32'd9, 2'b10, 6'b101010);
    step();
    check_eq("slt_a", out_a, 5);
    check_eq("slt_b", out_b, 9);
    check_eq("slt_op", out_op, 3'b111);
    check_eq("slt_ill", out_illegal, 0);

    // MEM beats WB beats register file
    instr(5'd3, 32'h1111, 5'd0, 32'd0, 2'b00, 6'd0);
    mem_wen = 1; mem_waddr = 5'd3; mem_wdata = 32'hAAAA;
    wb_wen = 1; wb_waddr = 5'd3; wb_wdata = 32'hBBBB;
    step();
    check_eq("fwd_mem_prio", out_a, fwd_en() ? 32'hAAAA : 32'h1111);
    mem_waddr = 0; wb_waddr = 0;
    step();
    check_eq("fwd_r0_ignored", out_a, 32'h1111);

    // Stall with WB snoop on the held rt
    idle();
    instr(5'd0, 32'd0, 5'd4, 32'h10, 2'b00, 6'd0);
    step();
    idle();
    out_ready = 0;
    step();
    wb_wen = 1; wb_waddr = 5'd4; wb_wdata = 32'h55;
    step();
    check_eq("snoop_b", out_b, fwd_en() ? 32'h55 : 32'h10);
    wb_wen = 0;
    step();
    check_eq("stall_at_release", stall_cnt, 3);
    out_ready = 1;
    step();

    // Flush while holding: new instruction refused
    instr(5'd1, 32'd1, 5'd2, 32'd2, 2'b00, 6'd0);
    step();
    out_ready = 0; flush = 1;
    instr(5'd5, 32'd50, 5'd6, 32'd60, 2'b01, 6'd0);
    step();
    check_eq("flush_valid", out_valid, 0);
    idle();
    step();
    check_eq("flush_no_capture", out_valid, 0);

    // Decode corners
    instr(5'd1, 32'd1, 5'd2, 32'd2, 2'b10, 6'b000000);
    step();
    check_eq("bad_funct_op", out_op, 3'b011);
    check_eq("bad_funct_ill", out_illegal, 1);
    instr(5'd1, 32'd1, 5'd2, 32'd2, 2'b11, 6'b000000);
    step();
    check_eq("ori_op", out_op, 3'b001);

    // Saturation, then reset in the middle of the stall
    idle();
    out_ready = 0;
    for (int i = 0; i < 20; i++) step();
    check_eq("stall_saturate", stall_cnt, StallMax);
    reset = 1;
    step();
    check_eq("midstall_rst_valid", out_valid, 0);
    check_eq("midstall_rst_stall", stall_cnt, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      in_rs_addr = 5'($urandom_range(0, 7));
      in_rt_addr = 5'($urandom_range(0, 7));
      in_rd_addr = 5'($urandom_range(0, 31));
      in_rs_data = $urandom;
      in_rt_data = $urandom;
      in_imm     = $urandom;
      in_aluop   = 2'($urandom_range(0, 3));
      in_funct   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(32, 42)) : 6'($urandom);
      in_alusrc  = 1'($urandom_range(0, 1));
      in_regdst  = 1'($urandom_range(0, 1));
      mem_wen    = 1'($urandom_range(0, 1));
      mem_waddr  = 5'($urandom_range(0, 7));
      mem_wdata  = $urandom;
      wb_wen     = 1'($urandom_range(0, 1));
      wb_waddr   = 5'($urandom_range(0, 7));
      wb_wdata   = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
